// File: rtl/dshot_rx_multirate_if.sv
// Pin-side and frame-side signals of the multirate DShot receiver.
// The receiver takes the slave modport; the pin driver and the frame consumer take the master modport.
interface dshot_rx_multirate_if #(
  parameter int ERRCNT_W = 8
);
  logic                dshot_in;
  logic [1:0]          rate_sel;
  logic                frame_valid;
  logic [15:0]         frame_data;
  logic [10:0]         throttle;
  logic                telemetry_req;
  logic                is_command;
  logic                crc_ok;
  logic                frame_err;
  logic [1:0]          err_code;
  logic [ERRCNT_W-1:0] crc_err_cnt;

  modport master (
    output dshot_in, rate_sel,
    input  frame_valid, frame_data, throttle, telemetry_req, is_command,
           crc_ok, frame_err, err_code, crc_err_cnt
  );

  modport slave (
    input  dshot_in, rate_sel,
    output frame_valid, frame_data, throttle, telemetry_req, is_command,
           crc_ok, frame_err, err_code, crc_err_cnt
  );
endinterface

// File: rtl/dshot_rx_multirate.sv
// DShot150/300/600/1200 receiver: classifies bits by pulse width, checks timing and CRC, pulses frame_valid 3 clk after the 16th falling edge.
// Optional DSHOT_BIDIR_EN: line inverted after the synchroniser and the CRC compared in inverted form.
module dshot_rx_multirate #(
  parameter int CLK_HZ   = 48000000,
  parameter int CNT_W    = 10,
  parameter int ERRCNT_W = 8
) (
  input logic                  clk,
  input logic                  reset,
  dshot_rx_multirate_if.slave  bus
);

  localparam int T0 = CLK_HZ / 150000;
  localparam int T1 = CLK_HZ / 300000;
  localparam int T2 = CLK_HZ / 600000;
  localparam int T3 = CLK_HZ / 1200000;

  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

  state_t              state_q, state_d;
  logic                sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [1:0]          rate_q, rate_d;
  logic [CNT_W-1:0]    hi_cnt_q, hi_cnt_d, per_cnt_q, per_cnt_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [14:0]         shift_q, shift_d;
  logic [15:0]         frame_data_q, frame_data_d;
  logic                crc_ok_q, crc_ok_d;
  logic                frame_valid_q, frame_valid_d;
  logic                frame_err_q, frame_err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [ERRCNT_W-1:0] crc_err_cnt_q, crc_err_cnt_d;

  logic             line, line_prev, rise, fall, bit_v;
  logic [15:0]      new_data;
  logic [CNT_W-1:0] t_min, t_half, t_max, t_2t;

  function automatic logic crc_match(input logic [15:0] f);
    logic [3:0] c;
    c = f[7:4] ^ f[11:8] ^ f[15:12];
`ifdef DSHOT_BIDIR_EN
    return f[3:0] == ~c;
`else
    return f[3:0] == c;
`endif
  endfunction

`ifdef DSHOT_BIDIR_EN
  assign line      = ~sync2_q;
  assign line_prev = ~sync3_q;
`else
  assign line      = sync2_q;
  assign line_prev = sync3_q;
`endif
  assign rise = line & ~line_prev;
  assign fall = ~line & line_prev;

  // Thresholds follow the rate latched at frame start, never the live rate_sel.
  always_comb begin
    t_min  = CNT_W'(T0 / 8);
    t_half = CNT_W'(T0 / 2);
    t_max  = CNT_W'((7 * T0) / 8);
    t_2t   = CNT_W'(2 * T0);
    case (rate_q)
      2'd1: begin
        t_min = CNT_W'(T1 / 8); t_half = CNT_W'(T1 / 2);
        t_max = CNT_W'((7 * T1) / 8); t_2t = CNT_W'(2 * T1);
      end
      2'd2: begin
        t_min = CNT_W'(T2 / 8); t_half = CNT_W'(T2 / 2);
        t_max = CNT_W'((7 * T2) / 8); t_2t = CNT_W'(2 * T2);
      end
      2'd3: begin
        t_min = CNT_W'(T3 / 8); t_half = CNT_W'(T3 / 2);
        t_max = CNT_W'((7 * T3) / 8); t_2t = CNT_W'(2 * T3);
      end
      default: ;
    endcase
  end

  always_comb begin
    sync1_d       = bus.dshot_in;
    sync2_d       = sync1_q;
    sync3_d       = sync2_q;
    state_d       = state_q;
    rate_d        = rate_q;
    hi_cnt_d      = hi_cnt_q;
    per_cnt_d     = per_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    frame_data_d  = frame_data_q;
    crc_ok_d      = crc_ok_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    err_code_d    = err_code_q;
    crc_err_cnt_d = crc_err_cnt_q;
    bit_v         = hi_cnt_q >= t_half;
    new_data      = {shift_q, bit_v};

    case (state_q)
      IDLE: begin
        if (rise) begin
          rate_d    = bus.rate_sel;
          hi_cnt_d  = '0;
          per_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = HIGH;
        end
      end
      HIGH: begin
        hi_cnt_d  = hi_cnt_q + 1'b1;
        per_cnt_d = per_cnt_q + 1'b1;
        if (fall) begin
          if (hi_cnt_q < t_min || hi_cnt_q > t_max) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd1;
            state_d     = IDLE;
          end else begin
            shift_d   = new_data[14:0];
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 5'd15) begin
              frame_data_d  = new_data;
              crc_ok_d      = crc_match(new_data);
              frame_valid_d = 1'b1;
              if (!crc_match(new_data) && crc_err_cnt_q != '1)
                crc_err_cnt_d = crc_err_cnt_q + 1'b1;
              per_cnt_d = '0;
              state_d   = GAP;
            end else begin
              state_d = LOW;
            end
          end
        end else if (per_cnt_q == t_2t - 1'b1) begin
          // A line stuck high would otherwise wrap hi_cnt and misclassify.
          frame_err_d = 1'b1;
          err_code_d  = 2'd3;
          state_d     = IDLE;
        end
      end
      LOW: begin
        per_cnt_d = per_cnt_q + 1'b1;
        if (rise) begin
          if (per_cnt_q < t_max) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd2;
            state_d     = IDLE;
          end else begin
            hi_cnt_d  = '0;
            per_cnt_d = '0;
            state_d   = HIGH;
          end
        end else if (per_cnt_q == t_2t - 1'b1) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd3;
          state_d     = IDLE;
        end
      end
      GAP: begin
        // Any high level restarts the quiet-time count.
        if (line)
          per_cnt_d = '0;
        else if (per_cnt_q == t_2t - 1'b1)
          state_d = IDLE;
        else
          per_cnt_d = per_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      sync3_q       <= 1'b0;
      rate_q        <= '0;
      hi_cnt_q      <= '0;
      per_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      frame_data_q  <= '0;
      crc_ok_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= '0;
      crc_err_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      sync3_q       <= sync3_d;
      rate_q        <= rate_d;
      hi_cnt_q      <= hi_cnt_d;
      per_cnt_q     <= per_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      frame_data_q  <= frame_data_d;
      crc_ok_q      <= crc_ok_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
      crc_err_cnt_q <= crc_err_cnt_d;
    end
  end

  assign bus.frame_valid   = frame_valid_q;
  assign bus.frame_data    = frame_data_q;
  assign bus.throttle      = frame_data_q[15:5];
  assign bus.telemetry_req = frame_data_q[4];
  assign bus.is_command    = (frame_data_q[15:5] != 11'd0) && (frame_data_q[15:5] < 11'd48);
  assign bus.crc_ok        = crc_ok_q;
  assign bus.frame_err     = frame_err_q;
  assign bus.err_code      = err_code_q;
  assign bus.crc_err_cnt   = crc_err_cnt_q;

endmodule
